// File: rtl/iomem_gpio_pkg.sv
// Shared GPIO definitions: register offsets, default base address and
// a byte-strobe expansion helper used by the iomem bus decode.
package gpio_pkg;

   localparam logic [7:0] GPIO_BASE_ADDR = 8'h03;

   // Register offsets, taken from iomem_addr[4:2]
   localparam logic [2:0] GPIO_OUT      = 3'd0;
   localparam logic [2:0] GPIO_IN       = 3'd1;
   localparam logic [2:0] GPIO_OE       = 3'd2;
   localparam logic [2:0] GPIO_RISE_EN  = 3'd3;
   localparam logic [2:0] GPIO_FALL_EN  = 3'd4;
   localparam logic [2:0] GPIO_PEND     = 3'd5;
   localparam logic [2:0] GPIO_TOGGLE   = 3'd6;
   localparam logic [2:0] GPIO_RESERVED = 3'd7;

   // Expand the four byte strobes into a 32-bit bit mask
   function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
      strb_to_mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
   endfunction

endpackage

// File: rtl/iomem_gpio_if.sv
// picosoc iomem bus bundle: the CPU side is the master, peripherals are slaves.
interface iomem_gpio_if;

   logic        iomem_valid;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb;
   logic [31:0] iomem_addr;
   logic [31:0] iomem_wdata;
   logic [31:0] iomem_rdata;

   modport master (
      output iomem_valid,
      output iomem_wstrb,
      output iomem_addr,
      output iomem_wdata,
      input  iomem_ready,
      input  iomem_rdata
   );

   modport slave (
      input  iomem_valid,
      input  iomem_wstrb,
      input  iomem_addr,
      input  iomem_wdata,
      output iomem_ready,
      output iomem_rdata
   );

endinterface

// File: rtl/iomem_gpio_sync_edge.sv
// Input synchroniser plus edge detector. Stage 0 of the chain takes the raw
// pins; the last stage is the synchronised IN value. A prev register holds IN
// one cycle late so rise/fall are single-cycle pulses, gated by their enables.
module gpio_sync_edge #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [WIDTH-1:0] i_pins,
   input  logic [WIDTH-1:0] i_rise_en,
   input  logic [WIDTH-1:0] i_fall_en,
   output logic [WIDTH-1:0] o_in,
   output logic [WIDTH-1:0] o_rise,
   output logic [WIDTH-1:0] o_fall
);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
   logic [WIDTH-1:0]                  r_prev;

   // Shift raw pins through the synchroniser and remember last cycle's IN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_sync <= '0;
         r_prev <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_pins};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_in   = r_sync[SYNC_STAGES-1];
   assign o_rise =  o_in & ~r_prev & i_rise_en;
   assign o_fall = ~o_in &  r_prev & i_fall_en;

endmodule

// File: rtl/iomem_gpio.sv
// GPIO peripheral on the picosoc iomem bus: OUT/OE/edge-enable registers,
// sticky edge-pending bits with write-1-clear and a level interrupt.
// Every access is acknowledged with a single-cycle registered ready.
module iomem_gpio
   import gpio_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter logic [7:0]       BASE_ADDR   = GPIO_BASE_ADDR,
   parameter int               SYNC_STAGES = 2,
   parameter logic [WIDTH-1:0] RESET_OUT   = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             resetn,
   iomem_gpio_if.slave      bus,
   input  logic [WIDTH-1:0] gpio_in,
   output logic [WIDTH-1:0] gpio_out,
   output logic [WIDTH-1:0] gpio_oe,
   output logic             irq
);

   logic             r_ready;
   logic [31:0]      r_rdata;
   logic [WIDTH-1:0] r_out;
   logic [WIDTH-1:0] r_oe;
   logic [WIDTH-1:0] r_rise_en;
   logic [WIDTH-1:0] r_fall_en;
   logic [WIDTH-1:0] r_pend;

   logic             w_hit;
   logic             w_mapped;
   logic             w_wr;
   logic [2:0]       w_off;
   logic [31:0]      w_mask32;
   logic [WIDTH-1:0] w_wmask;
   logic [WIDTH-1:0] w_wval;
   logic [WIDTH-1:0] w_clr;
   logic [WIDTH-1:0] w_in;
   logic [WIDTH-1:0] w_rise;
   logic [WIDTH-1:0] w_fall;
   logic [WIDTH-1:0] w_rd_field;
   logic [31:0]      w_rd_val;
   logic             w_unused;

   // A new access is taken only when ready is low, so each transfer is 2 cycles
   assign w_hit    = bus.iomem_valid && !r_ready && (bus.iomem_addr[31:24] == BASE_ADDR);
   assign w_off    = bus.iomem_addr[4:2];
   assign w_mapped = (bus.iomem_addr[23:5] == 19'd0) && (w_off != GPIO_RESERVED);
   assign w_wr     = w_hit && w_mapped && (bus.iomem_wstrb != 4'b0000);
   assign w_mask32 = strb_to_mask(bus.iomem_wstrb);
   assign w_wmask  = w_mask32[WIDTH-1:0];
   assign w_wval   = bus.iomem_wdata[WIDTH-1:0] & w_wmask;

   // Byte lanes [1:0] and data bits above WIDTH carry no state
   assign w_unused = &{1'b0, bus.iomem_addr[1:0], bus.iomem_wdata, w_mask32};

   gpio_sync_edge #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_edge (
      .clk       (clk),
      .resetn    (resetn),
      .i_pins    (gpio_in),
      .i_rise_en (r_rise_en),
      .i_fall_en (r_fall_en),
      .o_in      (w_in),
      .o_rise    (w_rise),
      .o_fall    (w_fall)
   );

   // Write-1-clear mask for PEND, only on a real write to the PEND offset
   always_comb begin
      w_clr = {WIDTH{1'b0}};
      if (w_wr && (w_off == GPIO_PEND)) begin
         w_clr = w_wval;
      end else begin
         w_clr = {WIDTH{1'b0}};
      end
   end

   // Read mux; unmapped offsets and aliases read as zero
   always_comb begin
      w_rd_field = {WIDTH{1'b0}};
      w_rd_val   = 32'h0000_0000;
      case (w_off)
         GPIO_OUT:     w_rd_field = r_out;
         GPIO_IN:      w_rd_field = w_in;
         GPIO_OE:      w_rd_field = r_oe;
         GPIO_RISE_EN: w_rd_field = r_rise_en;
         GPIO_FALL_EN: w_rd_field = r_fall_en;
         GPIO_PEND:    w_rd_field = r_pend;
         default:      w_rd_field = {WIDTH{1'b0}};
      endcase
      if (!w_mapped) begin
         w_rd_field = {WIDTH{1'b0}};
      end else begin
         w_rd_field = w_rd_field;
      end
      w_rd_val[WIDTH-1:0] = w_rd_field;
   end

   // Bus acknowledge and read data, both captured on the accepting edge
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_ready <= 1'b0;
         r_rdata <= 32'h0000_0000;
      end else begin
         r_ready <= w_hit;
         r_rdata <= w_hit ? w_rd_val : 32'h0000_0000;
      end
   end

   // Software-visible configuration registers with per-byte write strobes
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_out     <= RESET_OUT;
         r_oe      <= {WIDTH{1'b0}};
         r_rise_en <= {WIDTH{1'b0}};
         r_fall_en <= {WIDTH{1'b0}};
      end else if (w_wr) begin
         case (w_off)
            GPIO_OUT:     r_out     <= (r_out     & ~w_wmask) | w_wval;
            GPIO_TOGGLE:  r_out     <= r_out ^ w_wval;
            GPIO_OE:      r_oe      <= (r_oe      & ~w_wmask) | w_wval;
            GPIO_RISE_EN: r_rise_en <= (r_rise_en & ~w_wmask) | w_wval;
            GPIO_FALL_EN: r_fall_en <= (r_fall_en & ~w_wmask) | w_wval;
            default:      r_out     <= r_out;
         endcase
      end else begin
         r_out <= r_out;
      end
   end

   // Sticky pending bits: a new edge wins over a simultaneous clear
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_pend <= {WIDTH{1'b0}};
      end else begin
         r_pend <= (r_pend & ~w_clr) | w_rise | w_fall;
      end
   end

   assign bus.iomem_ready = r_ready;
   assign bus.iomem_rdata = r_rdata;
   assign gpio_out        = r_out;
   assign gpio_oe         = r_oe;
   assign irq             = |r_pend;

endmodule

// File: tb/tb_iomem_gpio.sv
// Directed bench for iomem_gpio: an 8-bit instance for the main register,
// edge and bus-protocol checks and a 32-bit instance for byte strobes.
module tb_iomem_gpio;
   import gpio_pkg::*;

   localparam logic [31:0] BASE = 32'h0300_0000;

   logic        clk     = 1'b0;
   logic        resetn  = 1'b0;
   logic        r_valid = 1'b0;
   logic        r_sel32 = 1'b0;
   logic [3:0]  r_wstrb = 4'b0000;
   logic [31:0] r_addr  = 32'h0;
   logic [31:0] r_wdata = 32'h0;
   logic [7:0]  r_gin8  = 8'h00;
   logic [31:0] r_gin32 = 32'h0;

   logic [7:0]  w_out8, w_oe8;
   logic [31:0] w_out32, w_oe32;
   logic        w_irq8, w_irq32;
   logic        w_ready;
   logic [31:0] w_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   iomem_gpio_if bus8 ();
   iomem_gpio_if bus32 ();

   assign bus8.iomem_valid  = r_valid & ~r_sel32;
   assign bus8.iomem_wstrb  = r_wstrb;
   assign bus8.iomem_addr   = r_addr;
   assign bus8.iomem_wdata  = r_wdata;
   assign bus32.iomem_valid = r_valid & r_sel32;
   assign bus32.iomem_wstrb = r_wstrb;
   assign bus32.iomem_addr  = r_addr;
   assign bus32.iomem_wdata = r_wdata;
   assign w_ready = r_sel32 ? bus32.iomem_ready : bus8.iomem_ready;
   assign w_rdata = r_sel32 ? bus32.iomem_rdata : bus8.iomem_rdata;

   iomem_gpio #(
      .WIDTH(8), .BASE_ADDR(8'h03), .SYNC_STAGES(2), .RESET_OUT(8'h00)
   ) u_dut8 (
      .clk(clk), .resetn(resetn), .bus(bus8), .gpio_in(r_gin8),
      .gpio_out(w_out8), .gpio_oe(w_oe8), .irq(w_irq8)
   );

   iomem_gpio #(
      .WIDTH(32), .BASE_ADDR(8'h03), .SYNC_STAGES(2), .RESET_OUT(32'h0)
   ) u_dut32 (
      .clk(clk), .resetn(resetn), .bus(bus32), .gpio_in(r_gin32),
      .gpio_out(w_out32), .gpio_oe(w_oe32), .irq(w_irq32)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] reg_addr(input logic [2:0] off);
      return BASE | {27'd0, off, 2'b00};
   endfunction

   // One bus transfer: waits at most 10 cycles for ready, then checks ready
   // is gone on the following cycle.
   task automatic bus_xfer(input string tag, input logic [31:0] addr, input logic [3:0] strb,
                           input logic [31:0] wdata, output logic [31:0] rdata);
      logic got;
      got   = 1'b0;
      rdata = 32'h0;
      @(negedge clk);
      r_addr  = addr;
      r_wstrb = strb;
      r_wdata = wdata;
      r_valid = 1'b1;
      for (int cyc = 0; cyc < 10 && !got; cyc++) begin
         @(posedge clk);
         #1;
         if (w_ready) begin
            got   = 1'b1;
            rdata = w_rdata;
         end
      end
      r_valid = 1'b0;
      check_eq({tag, "_ack"}, {31'd0, got}, 32'd1);
      @(posedge clk);
      #1;
      check_eq({tag, "_ack1cyc"}, {31'd0, w_ready}, 32'd0);
   endtask

   task automatic wr(input string tag, input logic [2:0] off, input logic [3:0] strb,
                     input logic [31:0] data);
      logic [31:0] dummy;
      bus_xfer(tag, reg_addr(off), strb, data, dummy);
   endtask

   // Reads use non-zero wdata to show a wstrb=0 access has no write effect
   task automatic rd(input string tag, input logic [2:0] off, input logic [31:0] exp);
      logic [31:0] val;
      bus_xfer(tag, reg_addr(off), 4'b0000, 32'hFFFF_FFFF, val);
      check_eq(tag, val, exp);
   endtask

   initial begin
      logic [31:0] val;
      int          cnt;

      // Reset state
      resetn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_out", {24'd0, w_out8}, 32'h0);
      check_eq("rst_oe", {24'd0, w_oe8}, 32'h0);
      check_eq("rst_irq", {31'd0, w_irq8}, 32'h0);
      check_eq("rst_ready", {31'd0, w_ready}, 32'h0);
      @(negedge clk);
      resetn = 1'b1;
      for (int i = 0; i < 7; i++) begin
         logic [2:0] off;
         off = i[2:0];
         rd($sformatf("rst_rd%0d", i), off, 32'h0);
      end

      // OUT byte write, then TOGGLE
      wr("out_a5", GPIO_OUT, 4'b0001, 32'h0000_00A5);
      check_eq("pin_a5", {24'd0, w_out8}, 32'h0000_00A5);
      wr("tog_0f", GPIO_TOGGLE, 4'b1111, 32'h0000_000F);
      check_eq("pin_aa", {24'd0, w_out8}, 32'h0000_00AA);
      rd("rd_aa", GPIO_OUT, 32'h0000_00AA);
      rd("rd_tog", GPIO_TOGGLE, 32'h0);

      // Bits above WIDTH are not stored; lane 1 is beyond an 8-bit block
      wr("out_ff", GPIO_OUT, 4'b1111, 32'hFFFF_FFFF);
      rd("rd_ff", GPIO_OUT, 32'h0000_00FF);
      wr("out_lane1", GPIO_OUT, 4'b0010, 32'h0000_1200);
      rd("rd_lane1", GPIO_OUT, 32'h0000_00FF);
      wr("oe_3c", GPIO_OE, 4'b1111, 32'h0000_003C);
      check_eq("pin_oe", {24'd0, w_oe8}, 32'h0000_003C);
      rd("rd_oe", GPIO_OE, 32'h0000_003C);

      // Edge detection latency and pending bits
      wr("rise_en", GPIO_RISE_EN, 4'b0001, 32'h0000_0001);
      wr("fall_en", GPIO_FALL_EN, 4'b0001, 32'h0000_0002);
      rd("rd_rise_en", GPIO_RISE_EN, 32'h0000_0001);
      @(negedge clk);
      r_gin8 = 8'h03;
      @(posedge clk); #1;
      check_eq("irq_e1", {31'd0, w_irq8}, 32'd0);
      @(posedge clk); #1;
      check_eq("irq_e2", {31'd0, w_irq8}, 32'd0);
      @(posedge clk); #1;
      check_eq("irq_e3", {31'd0, w_irq8}, 32'd1);
      rd("pend_rise", GPIO_PEND, 32'h0000_0001);
      rd("rd_in", GPIO_IN, 32'h0000_0003);
      @(negedge clk);
      r_gin8 = 8'h00;
      repeat (4) @(posedge clk);
      rd("pend_fall", GPIO_PEND, 32'h0000_0003);
      rd("pend_pure_rd", GPIO_PEND, 32'h0000_0003);
      wr("rise_en_off", GPIO_RISE_EN, 4'b1111, 32'h0);
      rd("pend_keep", GPIO_PEND, 32'h0000_0003);
      wr("rise_en_on", GPIO_RISE_EN, 4'b1111, 32'h0000_0001);
      wr("pend_w1c", GPIO_PEND, 4'b0001, 32'h0000_0003);
      rd("pend_clr", GPIO_PEND, 32'h0);
      check_eq("irq_clr", {31'd0, w_irq8}, 32'd0);

      // W1C racing a new rise on the same bit: the set wins
      @(negedge clk);
      r_gin8 = 8'h01;
      repeat (4) @(posedge clk);
      @(negedge clk);
      r_gin8 = 8'h00;
      repeat (4) @(posedge clk);
      rd("race_pre", GPIO_PEND, 32'h0000_0001);
      @(negedge clk);
      r_gin8 = 8'h01;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      r_addr  = reg_addr(GPIO_PEND);
      r_wstrb = 4'b0001;
      r_wdata = 32'h0000_0001;
      r_valid = 1'b1;
      @(posedge clk); #1;
      r_valid = 1'b0;
      check_eq("race_ack", {31'd0, w_ready}, 32'd1);
      check_eq("race_irq", {31'd0, w_irq8}, 32'd1);
      @(posedge clk); #1;
      check_eq("race_irq2", {31'd0, w_irq8}, 32'd1);
      rd("race_pend", GPIO_PEND, 32'h0000_0001);

      // Unmapped offsets and aliases
      rd("rd_rsvd", GPIO_RESERVED, 32'h0);
      bus_xfer("wr_alias", BASE | 32'h0000_0020, 4'b1111, 32'h0000_0055, val);
      rd("alias_noeff", GPIO_OUT, 32'h0000_00FF);
      bus_xfer("rd_alias", BASE | 32'h0000_0020, 4'b0000, 32'h0, val);
      check_eq("rd_alias_val", val, 32'h0);

      // Foreign address is never acknowledged
      @(negedge clk);
      r_addr  = 32'h0400_0000;
      r_wstrb = 4'b0000;
      r_valid = 1'b1;
      cnt = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (w_ready) cnt++;
      end
      r_valid = 1'b0;
      check_eq("foreign_noack", cnt, 32'd0);

      // Reset during an acknowledge drops ready immediately
      @(negedge clk);
      r_addr  = reg_addr(GPIO_OUT);
      r_wstrb = 4'b0001;
      r_wdata = 32'h0000_0077;
      r_valid = 1'b1;
      @(posedge clk); #1;
      check_eq("mid_ack", {31'd0, w_ready}, 32'd1);
      resetn = 1'b0;
      #1;
      check_eq("mid_rst_ready", {31'd0, w_ready}, 32'd0);
      check_eq("mid_rst_out", {24'd0, w_out8}, 32'h0);
      r_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      rd("post_rst_out", GPIO_OUT, 32'h0);

      // Byte strobes on the 32-bit instance
      r_sel32 = 1'b1;
      wr("w32_lane2", GPIO_OUT, 4'b0100, 32'h1122_3344);
      rd("rd32_lane2", GPIO_OUT, 32'h0022_0000);
      check_eq("pin32", w_out32, 32'h0022_0000);
      wr("tog32", GPIO_TOGGLE, 4'b1001, 32'h8000_0001);
      rd("rd32_tog", GPIO_OUT, 32'h8022_0001);
      r_sel32 = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
